polyt1_pack: RTL

POLYT1_PACK -- requirements
Module: polyt1_pack

---
 rtl/polyt1_pack.sv | 117 +++++++++++
 1 files changed

// File: rtl/polyt1_pack.sv
// Packs 256 coefficients into 320 bytes at 10 bits each (Dilithium polyt1_pack), one 4-coefficient group per LOAD/EMIT pair.
// Optional POLYT1_PACK_RANGE_CHECK_EN adds a sticky range_err output flagging coefficients outside [0,1023].
module polyt1_pack (
  input  logic          clock,
  input  logic          reset,
  input  logic          rtr,
  input  logic [8191:0] linear_t1,
  output logic [2559:0] linear_r,
  output logic          rts
`ifdef POLYT1_PACK_RANGE_CHECK_EN
  ,
  output logic          range_err
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    INIT = 3'd2,
    LOAD = 3'd3,
    EMIT = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [5:0]    r_g;
  logic [9:0]    r_t0, r_t1, r_t2, r_t3;
  logic [2559:0] r_linear_r;
  logic [12:0]   w_ibase;
  logic [11:0]   w_obase;

  // Group g reads coefficients 4g..4g+3 (128 bits) and writes bytes 5g..5g+4 (40 bits).
  assign w_ibase = {r_g, 7'd0};
  assign w_obase = {1'b0, r_g, 5'd0} + {3'd0, r_g, 3'd0};

`ifdef POLYT1_PACK_RANGE_CHECK_EN
  logic [31:0] w_c0, w_c1, w_c2, w_c3;
  logic        w_oor;
  logic        r_range_err;

  assign w_c0  = linear_t1[w_ibase +: 32];
  assign w_c1  = linear_t1[w_ibase + 13'd32 +: 32];
  assign w_c2  = linear_t1[w_ibase + 13'd64 +: 32];
  assign w_c3  = linear_t1[w_ibase + 13'd96 +: 32];
  // Negative values have the sign bit set, so any nonzero upper bit means out of range.
  assign w_oor = (|w_c0[31:10]) | (|w_c1[31:10]) | (|w_c2[31:10]) | (|w_c3[31:10]);
  assign range_err = r_range_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_range_err <= 1'b0;
    end else if (r_state == INIT) begin
      r_range_err <= 1'b0;
    end else if (r_state == LOAD) begin
      r_range_err <= r_range_err | w_oor;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = WAIT;
      WAIT:    w_next = rtr ? INIT : WAIT;
      INIT:    w_next = LOAD;
      LOAD:    w_next = EMIT;
      EMIT:    w_next = (r_g == 6'd63) ? DONE : LOAD;
      DONE:    w_next = rtr ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_g        <= 6'd0;
      r_t0       <= 10'd0;
      r_t1       <= 10'd0;
      r_t2       <= 10'd0;
      r_t3       <= 10'd0;
      r_linear_r <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_g        <= 6'd0;
          r_linear_r <= '0;
        end
        LOAD: begin
          r_t0 <= linear_t1[w_ibase +: 10];
          r_t1 <= linear_t1[w_ibase + 13'd32 +: 10];
          r_t2 <= linear_t1[w_ibase + 13'd64 +: 10];
          r_t3 <= linear_t1[w_ibase + 13'd96 +: 10];
        end
        EMIT: begin
          // Four 10-bit values laid end to end LSB-first form exactly the five output bytes.
          r_linear_r[w_obase +: 40] <= {r_t3, r_t2, r_t1, r_t0};
          if (r_g != 6'd63) begin
            r_g <= r_g + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign linear_r = r_linear_r;
  assign rts      = (r_state == DONE);

endmodule
